// File: rtl/conv_src_responder.sv
// Operand store for the convolution engine: one feature map and one kernel, filled by a
// host load stream and served through two image read ports and one kernel read port.
module conv_src_responder #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 8,
  parameter int KER_N  = 16,
  parameter int IA_W   = 10,
  parameter int KA_W   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ld_start,
  input  logic              i_ld_sel,
  input  logic              i_ld_valid,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic              o_ld_busy,
  output logic              o_ready,
  input  logic              i_a_req,
  input  logic [IA_W-1:0]   i_a_addr,
  output logic              o_a_valid,
  output logic [DATA_W-1:0] o_a_data,
  input  logic              i_b_req,
  input  logic [IA_W-1:0]   i_b_addr,
  output logic              o_b_valid,
  output logic [DATA_W-1:0] o_b_data,
  input  logic              i_k_req,
  input  logic [KA_W-1:0]   i_k_addr,
  output logic              o_k_valid,
  output logic [DATA_W-1:0] o_k_data,
  input  logic              i_err_clr,
  output logic [1:0]        o_err
);

  localparam int IMG_N = IMG_W * IMG_H;

  typedef enum logic [1:0] {IDLE, LOAD_IMG, LOAD_KER} state_t;

  state_t              state_q, state_d;
  logic [IA_W-1:0]     cnt_q, cnt_d;
  logic                img_loaded_q, img_loaded_d;
  logic                ker_loaded_q, ker_loaded_d;
  logic                img_we, ker_we;
  logic                ready;

  logic [DATA_W-1:0]   img_mem [IMG_N];
  logic [DATA_W-1:0]   ker_mem [KER_N];

  logic                a_valid_q, a_valid_d, b_valid_q, b_valid_d, k_valid_q, k_valid_d;
  logic [DATA_W-1:0]   a_data_q, a_data_d, b_data_q, b_data_d, k_data_q, k_data_d;
  logic [1:0]          err_q, err_d;
  logic                a_oor, b_oor, k_oor;

  // Load sequencing; a start pulse always wins over a beat in the same cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    img_loaded_d = img_loaded_q;
    ker_loaded_d = ker_loaded_q;
    img_we       = 1'b0;
    ker_we       = 1'b0;
    if (i_ld_start) begin
      cnt_d = '0;
      if (i_ld_sel) begin
        state_d      = LOAD_KER;
        ker_loaded_d = 1'b0;
      end else begin
        state_d      = LOAD_IMG;
        img_loaded_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        LOAD_IMG: begin
          if (i_ld_valid) begin
            img_we = 1'b1;
            cnt_d  = cnt_q + IA_W'(1);
            if (cnt_q == IA_W'(IMG_N - 1)) begin
              img_loaded_d = 1'b1;
              state_d      = IDLE;
              cnt_d        = '0;
            end
          end
        end
        LOAD_KER: begin
          if (i_ld_valid) begin
            ker_we = 1'b1;
            cnt_d  = cnt_q + IA_W'(1);
            if (cnt_q == IA_W'(KER_N - 1)) begin
              ker_loaded_d = 1'b1;
              state_d      = IDLE;
              cnt_d        = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (img_we) img_mem[cnt_q] <= i_ld_data;
    if (ker_we) ker_mem[cnt_q[KA_W-1:0]] <= i_ld_data;
  end

  assign ready = img_loaded_q & ker_loaded_q & (state_q == IDLE);

  // Writes only happen while not ready, so reads never see a same-cycle write.
  always_comb begin
    a_oor     = ({1'b0, i_a_addr} >= (IA_W+1)'(IMG_N));
    b_oor     = ({1'b0, i_b_addr} >= (IA_W+1)'(IMG_N));
    k_oor     = ({1'b0, i_k_addr} >= (KA_W+1)'(KER_N));
    a_valid_d = i_a_req & ready;
    b_valid_d = i_b_req & ready;
    k_valid_d = i_k_req & ready;
    a_data_d  = a_data_q;
    b_data_d  = b_data_q;
    k_data_d  = k_data_q;
    if (a_valid_d) a_data_d = a_oor ? '0 : img_mem[i_a_addr];
    if (b_valid_d) b_data_d = b_oor ? '0 : img_mem[i_b_addr];
    if (k_valid_d) k_data_d = k_oor ? '0 : ker_mem[i_k_addr];
    err_d    = err_q & ~{2{i_err_clr}};
    err_d[0] = err_d[0] | (a_valid_d & a_oor) | (b_valid_d & b_oor) | (k_valid_d & k_oor);
    err_d[1] = err_d[1] | ((i_a_req | i_b_req | i_k_req) & ~ready);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      img_loaded_q <= 1'b0;
      ker_loaded_q <= 1'b0;
      a_valid_q    <= 1'b0;
      b_valid_q    <= 1'b0;
      k_valid_q    <= 1'b0;
      a_data_q     <= '0;
      b_data_q     <= '0;
      k_data_q     <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      img_loaded_q <= img_loaded_d;
      ker_loaded_q <= ker_loaded_d;
      a_valid_q    <= a_valid_d;
      b_valid_q    <= b_valid_d;
      k_valid_q    <= k_valid_d;
      a_data_q     <= a_data_d;
      b_data_q     <= b_data_d;
      k_data_q     <= k_data_d;
      err_q        <= err_d;
    end
  end

  assign o_ld_busy = (state_q != IDLE);
  assign o_ready   = ready;
  assign o_a_valid = a_valid_q;
  assign o_a_data  = a_data_q;
  assign o_b_valid = b_valid_q;
  assign o_b_data  = b_data_q;
  assign o_k_valid = k_valid_q;
  assign o_k_data  = k_data_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_conv_src_responder.sv
// Bench for conv_src_responder: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the load stream and the three read ports.
module tb_conv_src_responder;

  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int IMG_N  = IMG_W * IMG_H;
  localparam int DATA_W = 8;
  localparam int KER_N  = 16;
  localparam int IA_W   = 10;
  // One spare kernel address bit so out-of-range kernel reads can be issued.
  localparam int KA_W   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              ld_start, ld_sel, ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_busy, ready;
  logic              a_req, b_req, k_req;
  logic [IA_W-1:0]   a_addr, b_addr;
  logic [KA_W-1:0]   k_addr;
  logic              a_valid, b_valid, k_valid;
  logic [DATA_W-1:0] a_data, b_data, k_data;
  logic              err_clr;
  logic [1:0]        err;

  conv_src_responder #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W),
    .KER_N(KER_N), .IA_W(IA_W), .KA_W(KA_W)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ld_start(ld_start), .i_ld_sel(ld_sel), .i_ld_valid(ld_valid), .i_ld_data(ld_data),
    .o_ld_busy(ld_busy), .o_ready(ready),
    .i_a_req(a_req), .i_a_addr(a_addr), .o_a_valid(a_valid), .o_a_data(a_data),
    .i_b_req(b_req), .i_b_addr(b_addr), .o_b_valid(b_valid), .o_b_data(b_data),
    .i_k_req(k_req), .i_k_addr(k_addr), .o_k_valid(k_valid), .o_k_data(k_data),
    .i_err_clr(err_clr), .o_err(err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] img_ref [IMG_N];
  logic [7:0] ker_ref [KER_N];
  logic       m_busy, m_sel, m_img, m_ker;
  int         m_cnt;
  logic       e_av, e_bv, e_kv;
  logic [7:0] e_ad, e_bd, e_kd;
  logic [1:0] e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_img = 0; m_ker = 0; m_cnt = 0;
    e_av = 0; e_bv = 0; e_kv = 0; e_ad = 0; e_bd = 0; e_kd = 0; e_err = 0;
  endtask

  task automatic check_all();
    chk("ld_busy", 32'(ld_busy), 32'(m_busy));
    chk("ready",   32'(ready),   32'(m_img && m_ker && !m_busy));
    chk("a_valid", 32'(a_valid), 32'(e_av));
    chk("a_data",  32'(a_data),  32'(e_ad));
    chk("b_valid", 32'(b_valid), 32'(e_bv));
    chk("b_data",  32'(b_data),  32'(e_bd));
    chk("k_valid", 32'(k_valid), 32'(e_kv));
    chk("k_data",  32'(k_data),  32'(e_kd));
    chk("err",     32'(err),     32'(e_err));
  endtask

  // One clock: advance the model from the inputs present at the edge, then compare.
  task automatic cyc();
    logic       rdy;
    logic [1:0] ev;
    @(posedge clk);
    rdy = m_img && m_ker && !m_busy;
    ev  = 2'b00;
    e_av = a_req && rdy;
    e_bv = b_req && rdy;
    e_kv = k_req && rdy;
    if ((a_req || b_req || k_req) && !rdy) ev[1] = 1'b1;
    if (e_av) begin
      if (int'(a_addr) < IMG_N) e_ad = img_ref[a_addr];
      else begin e_ad = 0; ev[0] = 1'b1; end
    end
    if (e_bv) begin
      if (int'(b_addr) < IMG_N) e_bd = img_ref[b_addr];
      else begin e_bd = 0; ev[0] = 1'b1; end
    end
    if (e_kv) begin
      if (int'(k_addr) < KER_N) e_kd = ker_ref[k_addr];
      else begin e_kd = 0; ev[0] = 1'b1; end
    end
    e_err = (err_clr ? 2'b00 : e_err) | ev;
    if (ld_start) begin
      m_busy = 1; m_sel = ld_sel; m_cnt = 0;
      if (ld_sel) m_ker = 0; else m_img = 0;
    end else if (m_busy && ld_valid) begin
      if (m_sel) ker_ref[m_cnt] = ld_data; else img_ref[m_cnt] = ld_data;
      m_cnt++;
      if (m_cnt == (m_sel ? KER_N : IMG_N)) begin
        m_busy = 0;
        if (m_sel) m_ker = 1; else m_img = 1;
      end
    end
    #1;
    check_all();
  endtask

  // mode 0: byte = index, 1: index+1, 2: random. The start cycle may carry a beat to be dropped.
  task automatic load(input logic sel, input int n, input int mode);
    ld_start = 1; ld_sel = sel;
    ld_valid = 1'($urandom_range(0, 1));
    ld_data  = 8'($urandom);
    cyc();
    ld_start = 0;
    for (int i = 0; i < n; ) begin
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_data  = (mode == 0) ? 8'(i) : (mode == 1) ? 8'(i + 1) : 8'($urandom);
      cyc();
      if (ld_valid) i++;
    end
    ld_valid = 0;
    cyc();
  endtask

  task automatic rd(input logic ar, input int aa, input logic br, input int ba,
                    input logic kr, input int ka);
    a_req = ar; a_addr = IA_W'(aa);
    b_req = br; b_addr = IA_W'(ba);
    k_req = kr; k_addr = KA_W'(ka);
    cyc();
  endtask

  task automatic idle();
    a_req = 0; b_req = 0; k_req = 0;
    cyc();
  endtask

  initial begin
    ld_start = 0; ld_sel = 0; ld_valid = 0; ld_data = 0;
    a_req = 0; b_req = 0; k_req = 0; a_addr = 0; b_addr = 0; k_addr = 0;
    err_clr = 0;
    model_reset();
    rst = 1;
    #3;
    check_all();
    @(posedge clk); #1;
    rst = 0;
    cyc();

    // Fill: image with its own address bytes, kernel with 1..16
    load(1'b0, IMG_N, 0);
    chk("ready_img_only", 32'(ready), 32'd0);
    load(1'b1, KER_N, 1);
    chk("ready_both", 32'(ready), 32'd1);

    // Paired window fetches with a stride-2 offset
    rd(1, 0, 1, 2, 0, 0);
    chk("a_addr0", 32'(a_data), 32'd0);
    chk("b_addr2", 32'(b_data), 32'd2);
    rd(1, 28, 1, 30, 0, 0);
    chk("a_addr28", 32'(a_data), 32'd28);
    chk("b_addr30", 32'(b_data), 32'd30);
    rd(1, 500, 1, 500, 0, 0);
    chk("ab_same", 32'(b_data), 32'(a_data));
    idle();
    chk("a_hold_invalid", 32'(a_valid), 32'd0);

    // Back-to-back kernel walk
    for (int i = 0; i < KER_N; i++) begin
      rd(0, 0, 0, 0, 1, i);
      chk("k_walk", 32'(k_data), 32'(i + 1));
    end
    idle();

    // Out-of-range reads, then clear
    rd(1, IMG_N, 0, 0, 1, KER_N);
    chk("oor_a", 32'(a_data), 32'd0);
    chk("oor_k", 32'(k_data), 32'd0);
    chk("oor_err", 32'(err), 32'd1);
    a_req = 0; k_req = 0; err_clr = 1;
    cyc();
    err_clr = 0;
    chk("err_cleared", 32'(err), 32'd0);
    // Clear coinciding with a new out-of-range event keeps the bit
    err_clr = 1;
    rd(0, 0, 1, 1023, 0, 0);
    err_clr = 0;
    chk("err_clr_vs_event", 32'(err), 32'd1);
    err_clr = 1; idle(); err_clr = 0;

    // Kernel load abandoned after 5 beats for an image load
    load(1'b1, 5, 2);
    load(1'b0, IMG_N, 2);
    chk("ready_ker_incomplete", 32'(ready), 32'd0);
    rd(1, 3, 1, 4, 1, 2);
    chk("notready_err", 32'(err), 32'd2);
    chk("notready_no_valid", 32'(a_valid | b_valid | k_valid), 32'd0);
    err_clr = 1; idle(); err_clr = 0;

    // Asynchronous reset in the middle of an image load
    ld_start = 1; ld_sel = 0; ld_valid = 0;
    cyc();
    ld_start = 0; ld_valid = 1;
    for (int i = 0; i < 300; i++) begin
      ld_data = 8'($urandom);
      cyc();
    end
    #2;
    rst = 1;
    #1;
    model_reset();
    check_all();
    ld_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    rd(1, 1, 0, 0, 0, 0);
    chk("after_reset_err", 32'(err), 32'd2);
    err_clr = 1; idle(); err_clr = 0;

    // Full reload with random contents, then mixed random traffic
    load(1'b1, KER_N, 2);
    load(1'b0, IMG_N, 2);
    for (int c = 0; c < 400; c++) begin
      err_clr = ($urandom_range(0, 7) == 0);
      rd(1'($urandom_range(0, 1)),
         ($urandom_range(0, 9) == 0) ? $urandom_range(IMG_N, 1023) : $urandom_range(0, IMG_N - 1),
         1'($urandom_range(0, 1)),
         ($urandom_range(0, 9) == 0) ? $urandom_range(IMG_N, 1023) : $urandom_range(0, IMG_N - 1),
         1'($urandom_range(0, 1)),
         ($urandom_range(0, 9) == 0) ? $urandom_range(KER_N, 31) : $urandom_range(0, KER_N - 1));
    end
    err_clr = 0;
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
